// File: rtl/add_sched.sv
// add_sched: packs paired A/B operand streams into LANES-wide add datapath
// registers, holds them for the datapath latency, then unpacks the captured
// sums onto a single result stream in input order.
module add_sched #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [31:0]           a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [31:0]           b_data,
  output logic [32*LANES-1:0]   dp_ra,
  output logic [32*LANES-1:0]   dp_rb,
  input  logic [32*LANES-1:0]   dp_ry,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [31:0]           y_data
);

  localparam int unsigned FILL_W = $clog2(LANES + 1);
  localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DW     = 32 * LANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]     ra_q, ra_d;
  logic [DW-1:0]     rb_q, rb_d;
  logic [DW-1:0]     res_q, res_d;
  logic              xfer;

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      fill_q     <= '0;
      out_idx_q  <= '0;
      wait_cnt_q <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      fill_q     <= fill_d;
      out_idx_q  <= out_idx_d;
      wait_cnt_q <= wait_cnt_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      res_q      <= res_d;
    end
  end

  // Next-state: group packing, latency wait, result unpacking.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    fill_d     = fill_q;
    out_idx_d  = out_idx_q;
    wait_cnt_d = wait_cnt_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    res_d      = res_q;
    xfer       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            remain_d = len;
            ra_d     = '0;
            rb_d     = '0;
            fill_d   = '0;
            state_d  = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (a_valid && b_valid) begin
          xfer = 1'b1;
          for (int unsigned i = 0; i < LANES; i++) begin
            if (fill_q == FILL_W'(i)) begin
              ra_d[32*i +: 32] = a_data;
              rb_d[32*i +: 32] = b_data;
            end
          end
          fill_d   = fill_q + FILL_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (fill_q == FILL_W'(LANES - 1) || remain_q == LEN_W'(1)) begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'(ADD_LAT)) begin
          res_d     = dp_ry;
          out_idx_d = '0;
          state_d   = S_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (y_ready) begin
          if (FILL_W'(out_idx_q) + FILL_W'(1) == fill_q) begin
            if (remain_q == '0) begin
              state_d = S_DONE;
            end else begin
              ra_d    = '0;
              rb_d    = '0;
              fill_d  = '0;
              state_d = S_LOAD;
            end
          end else begin
            out_idx_d = out_idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; y_data is zero outside DRAIN.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    a_ready = xfer;
    b_ready = xfer;
    y_valid = (state_q == S_DRAIN);
    dp_ra   = ra_q;
    dp_rb   = rb_q;
    y_data  = '0;
    if (state_q == S_DRAIN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (out_idx_q == IDX_W'(i)) begin
          y_data = res_q[32*i +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// Self-checking bench for add_sched: a one-register adder model stands in
// for the datapath, a scoreboard queue holds expected sums per transfer.
module tb_add_sched;

  localparam int unsigned LANES   = 4;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned LEN_W   = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [LEN_W-1:0]    len = '0;
  logic                busy, done;
  logic                a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
  logic                a_ready, b_ready, y_valid;
  logic [31:0]         a_data = '0, b_data = '0, y_data;
  logic [32*LANES-1:0] dp_ra, dp_rb;
  logic [32*LANES-1:0] dp_ry = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] opa[$];
  logic [31:0] opb[$];
  int          tcount = 0;
  int          ycount = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_d = '0;

  always #5 clock = ~clock;

  add_sched #(.LANES(LANES), .ADD_LAT(ADD_LAT), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .busy(busy), .done(done),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_ry(dp_ry),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
  );

  // Datapath model: one register stage of per-lane 32-bit adds.
  always @(posedge clock) begin
    for (int i = 0; i < int'(LANES); i++)
      dp_ry[32*i +: 32] <= dp_ra[32*i +: 32] + dp_rb[32*i +: 32];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes complete at the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      if (a_valid != b_valid)
        check("lone_valid_no_xfer", {62'd0, a_ready, b_ready}, 64'd0);
      if (a_valid && b_valid && a_ready && b_ready) begin
        exp_q.push_back(a_data + b_data);
        tcount++;
      end
      if (held_v && y_valid)
        check("y_stable", {32'd0, y_data}, {32'd0, held_d});
      if (y_valid && y_ready) begin
        ycount++;
        if (exp_q.size() == 0) check("y_unexpected", 64'd1, 64'd0);
        else check("y_data", {32'd0, y_data}, {32'd0, exp_q.pop_front()});
      end
      held_v = y_valid && !y_ready;
      held_d = y_data;
    end
  end

  task automatic run_job(input int n, input bit rnd, input int bhold, input bit poke,
                         input int abort_after, input int exp_cyc);
    int idx = 0;
    int cyc = 0;
    int bcnt = 0;
    bit got_done = 0;
    bit poked = 0;
    bit poke_now = 0;
    bit aborted = 0;
    tcount = 0;
    ycount = 0;
    start = 1'b1;
    len = LEN_W'(n);
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      if (abort_after > 0 && tcount == abort_after) begin
        aborted = 1;
        break;
      end
      start = poke_now;
      if (poke_now) len = LEN_W'(3);
      poke_now = 0;
      if (idx < n) begin
        a_data  = opa[idx];
        b_data  = opb[idx];
        a_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
        b_valid = (bcnt < bhold) ? 1'b0 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
        bcnt++;
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      y_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      @(negedge clock);
      cyc++;
      if (a_valid && b_valid && a_ready) idx++;
      if (done) begin
        got_done = 1;
        check("busy_in_done", {63'd0, busy}, 64'd1);
      end
      if (poke && !poked && y_valid) begin
        poked = 1;
        poke_now = 1;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (aborted) begin
      #1 reset = 1'b0;
      #1;
      check("abort_busy",    {63'd0, busy},    64'd0);
      check("abort_done",    {63'd0, done},    64'd0);
      check("abort_ready",   {62'd0, a_ready, b_ready}, 64'd0);
      check("abort_y_valid", {63'd0, y_valid}, 64'd0);
      check("abort_y_data",  {32'd0, y_data},  64'd0);
      check("abort_dp_ra",   {63'd0, |dp_ra},  64'd0);
      check("abort_dp_rb",   {63'd0, |dp_rb},  64'd0);
      exp_q.delete();
      held_v = 1'b0;
      repeat (2) @(negedge clock);
      check("abort_busy_held", {63'd0, busy}, 64'd0);
      reset = 1'b1;
      @(posedge clock); #1;
    end else begin
      check("done_seen", {63'd0, got_done}, 64'd1);
      if (exp_cyc > 0) check("done_latency", 64'(cyc), 64'(exp_cyc));
      check("in_count",  64'(tcount), 64'(n));
      check("out_count", 64'(ycount), 64'(n));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clock);
      check("done_pulse", {63'd0, done}, 64'd0);
      check("busy_after", {63'd0, busy}, 64'd0);
      @(posedge clock); #1;
    end
  endtask

  task automatic load_ops(input int n, input int mode);
    opa.delete();
    opb.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin opa.push_back(32'(i + 1)); opb.push_back(32'(10 * (i + 1))); end
        1: begin opa.push_back(32'(i));     opb.push_back(32'(i)); end
        default: begin opa.push_back($urandom); opb.push_back($urandom); end
      endcase
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy",    {63'd0, busy},    64'd0);
    check("rst_done",    {63'd0, done},    64'd0);
    check("rst_ready",   {62'd0, a_ready, b_ready}, 64'd0);
    check("rst_y_valid", {63'd0, y_valid}, 64'd0);
    check("rst_y_data",  {32'd0, y_data},  64'd0);
    check("rst_dp_ra",   {63'd0, |dp_ra},  64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // 1+10 .. 4+40 in one full group
    load_ops(4, 0);
    run_job(4, 0, 0, 0, 0, 11);

    // two groups, second one partial
    load_ops(6, 1);
    run_job(6, 0, 0, 0, 0, 17);
    check("part_lane0", {32'd0, dp_ra[31:0]},  64'd4);
    check("part_lane1", {32'd0, dp_ra[63:32]}, 64'd5);
    check("part_hi_ra", dp_ra[127:64], 64'd0);
    check("part_hi_rb", dp_rb[127:64], 64'd0);

    // carry dropped: 0xFFFFFFFF + 2
    opa.delete(); opb.delete();
    opa.push_back(32'hFFFF_FFFF); opb.push_back(32'd2);
    exp_q.delete();
    run_job(1, 0, 0, 0, 0, 5);

    // zero-length job
    run_job(0, 0, 0, 0, 0, 1);

    // random valid gaps, B held off 5 cycles, random backpressure
    load_ops(13, 2);
    run_job(13, 1, 5, 0, 0, 0);

    // start poked during DRAIN is ignored
    load_ops(9, 2);
    run_job(9, 0, 0, 1, 0, 25);
    load_ops(4, 0);
    run_job(4, 0, 0, 0, 0, 11);

    // reset during WAIT of an 8-element job, then a clean job
    load_ops(8, 2);
    run_job(8, 0, 0, 0, 4, 0);
    load_ops(4, 2);
    run_job(4, 0, 0, 0, 0, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
